video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Parametrised raster timing generator plus selectable test-pattern source for the HDMI path.
//  Produces sync/DE/coordinates and registered RGB, all cycle-aligned, for the TMDS encoder stage.
//  Supersedes the fixed 640x480 timing and single hard-wired pattern.
// PARAMETERS
//  CORDW    10   coordinate counter width; H_TOTAL, V_TOTAL <= 2**CORDW (elaboration $error otherwise)
//  COLW     8    bits per colour component, >= 8
//  H_ACTIVE 640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48
//  V_ACTIVE 480  visible lines/frame;  V_FP 10, V_SYNC 2,  V_BP 33
//  H_POL    0    hsync active level (0 = active-low);  V_POL 0 likewise for vsync
// PORTS
//  clk_pix      in   1        pixel clock; the only clock
//  rst          in   1        synchronous, active-high reset
//  mode         in   3        pattern select; sampled only at frame boundary
//  sx           out  CORDW    X of the pixel currently on rgb (blanking included)
//  sy           out  CORDW    Y of the pixel currently on rgb
//  hsync        out  1        horizontal sync, polarity H_POL
//  vsync        out  1        vertical sync, polarity V_POL
//  de           out  1        1 = sx < H_ACTIVE and sy < V_ACTIVE
//  frame_start  out  1        1-cycle pulse accompanying pixel (0,0)
//  rgb          out  3*COLW   {R,G,B}; 0 whenever de=0
// BEHAVIOUR
//  - Line: active [0,H_ACTIVE), then FP, SYNC, BP; H_TOTAL = sum. Frame: same order vertically.
//  - Internal counters hc/vc: hc wraps H_TOTAL-1 -> 0, incrementing vc; vc wraps V_TOTAL-1 -> 0.
//  - hsync active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vc.
//  - Latency: all outputs registered once from hc/vc; sx,sy,hsync,vsync,de,rgb,frame_start mutually aligned.
//  - Reset: hc=vc=0, sx=sy=0, hsync=~H_POL, vsync=~V_POL, de=0, rgb=0, frame_start=0,
//    mode_q=0 (black). First cycle after rst release: outputs show pixel (0,0) with frame_start=1.
//    rst mid-frame aborts the frame; the same sequence restarts immediately.
//  - mode_q <= mode when hc=H_TOTAL-1 and vc=V_TOTAL-1; never changes mid-frame.
//  - Patterns (8-bit values p; COLW>8 -> left-aligned, LSBs zero), x = sx, y = sy:
//    0 black; 1 XOR: R={x[5:0]&{6{y[4:3]==~x[4:3]}},2'b00}, G=x[7:0]&{8{y[6]}}, B=y[7:0];
//    2 colour bars: idx=min(x/(H_ACTIVE/8),7); white,yellow,cyan,green,magenta,red,blue,black (FF/00);
//    3 border: R=FF at x=0, G=FF at y=0, B=FF at x=H_ACTIVE-1 or y=V_ACTIVE-1, else 0;
//    4 checker: 32x32 cells, white when x[5]^y[5], else black; 5 grey ramp: R=G=B=x[7:0];
//    6,7 solid white.
//  - Pattern values computed from hc/vc in the same stage as de (no extra latency).
// CONFIGURATION
//  PATTERN_ANIM_EN defined: 8-bit frame_cnt, reset 0, +1 at each frame_start (wraps 255->0);
//    modes 1,4,5 use x = sx + frame_cnt (mod 2**CORDW) -> pattern scrolls left 1 px/frame.
//  Not defined: no frame_cnt register; all patterns static. Timing identical in both builds.
// STRUCTURE
//  video_pkg: pattern_mode_e enum (PAT_BLACK..PAT_WHITE), colour-bar RGB constant table,
//    sync polarity constants.
//  Sub-module video_timing_counter: hc/vc counters, raw hsync/vsync/de/last-pixel flag;
//    top adds mode latch, pattern mux, output register.
// TESTING
//  1 default params, rst 3 cycles -> first post-reset cycle sx=0,sy=0,de=1,frame_start=1,hsync=vsync=1.
//  2 free-run 2 frames -> frame_start period 420000 cycles; de high 640 cycles/line, 480 lines;
//    hsync low sx 656..751; vsync low sy 490..491.
//  3 mode=2 -> rgb=FFFFFF at sx=0, FFFF00 at sx=80, 000000 at sx=639 and whenever de=0.
//  4 mode 0->3 switched at sy=100 -> stays black to frame end; border from next frame_start
//    (FF0000 at (0,5), 00FF00 at (5,0)).
//  5 assert rst at (300,200) for 1 cycle -> next cycle sx=sy=0, frame_start=1, mode_q=0.
//  6 PATTERN_ANIM_EN, mode=5 -> frame N pixel (0,y) R=G=B=N mod 256; non-anim build -> 00.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: pattern mode encoding, colour-bar table and sync polarity constants
package video_pkg;
  typedef enum logic [2:0] {
    PAT_BLACK, PAT_XOR, PAT_BARS, PAT_BORDER, PAT_CHECKER, PAT_RAMP, PAT_WHITE
  } pattern_mode_e;
  localparam logic SYNC_ACT_LOW = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000ff, 24'hff0000, 24'hff00ff,
    24'h00ff00, 24'h00ffff, 24'hffff00, 24'hffffff
  };
endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: raster hc/vc counters with raw sync, active-area and last-pixel flags
//   clk_pix, rst (sync, active-high) -> hc, vc, hs_act/vs_act (sync interval, polarity-free),
//   de (active area), last_px (final pixel of the frame)
module video_timing_counter #(
  parameter int CORDW = 10,
  parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic [CORDW-1:0] hc,
  output logic [CORDW-1:0] vc,
  output logic             hs_act,
  output logic             vs_act,
  output logic             de,
  output logic             last_px
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic h_end, v_end;
  assign h_end = hc == CORDW'(H_TOTAL - 1);
  assign v_end = vc == CORDW'(V_TOTAL - 1);
  assign last_px = h_end && v_end;
  assign de = hc < CORDW'(H_ACTIVE) && vc < CORDW'(V_ACTIVE);
  assign hs_act = hc >= CORDW'(H_ACTIVE + H_FP) && hc < CORDW'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_act = vc >= CORDW'(V_ACTIVE + V_FP) && vc < CORDW'(V_ACTIVE + V_FP + V_SYNC);
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= h_end ? '0 : hc + CORDW'(1);
      if (h_end) vc <= v_end ? '0 : vc + CORDW'(1);
    end
  end
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator with selectable, registered test-pattern output
//   clk_pix, rst (sync, active-high), mode (latched at frame end) ->
//   sx/sy (coordinate on rgb), hsync/vsync (H_POL/V_POL), de, frame_start (pixel 0,0), rgb {R,G,B}
//   PATTERN_ANIM_EN: per-frame counter scrolls the XOR, checker and ramp patterns left 1 px/frame
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int   CORDW = 10,
  parameter int   COLW = 8,
  parameter int   H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int   V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33,
  parameter logic H_POL = SYNC_ACT_LOW,
  parameter logic V_POL = SYNC_ACT_LOW
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic [2:0]        mode,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic [3*COLW-1:0] rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 2**CORDW || V_TOTAL > 2**CORDW || CORDW < 8 || COLW < 8) begin : g_bad_params
    $error("video_pattern_gen: CORDW too small for the raster or COLW < 8");
  end
  logic [CORDW-1:0] hc, vc, bar_q;
  logic hs_act, vs_act, de_raw, last_px;
  logic [2:0] bar_idx;
  logic [7:0] xa;
  logic [23:0] p;
  pattern_mode_e mode_q;
  video_timing_counter #(
    .CORDW(CORDW),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_pix(clk_pix),
    .rst(rst),
    .hc(hc),
    .vc(vc),
    .hs_act(hs_act),
    .vs_act(vs_act),
    .de(de_raw),
    .last_px(last_px)
  );
`ifdef PATTERN_ANIM_EN
  logic [7:0] frame_cnt;
  // advancing on the last pixel makes the new count visible from pixel (0,0) onwards
  always_ff @(posedge clk_pix) begin
    if (rst) frame_cnt <= '0;
    else if (last_px) frame_cnt <= frame_cnt + 8'd1;
  end
  assign xa = hc[7:0] + frame_cnt;
`else
  assign xa = hc[7:0];
`endif
  assign bar_q = hc / CORDW'(H_ACTIVE / 8);
  assign bar_idx = bar_q > CORDW'(7) ? 3'd7 : bar_q[2:0];
  always_comb begin
    p = '0;
    case (mode_q)
      PAT_BLACK:   p = '0;
      PAT_XOR:     p = {xa[5:0] & {6{vc[4:3] == ~xa[4:3]}}, 2'b00, xa & {8{vc[6]}}, vc[7:0]};
      PAT_BARS:    p = BAR_RGB[bar_idx];
      PAT_BORDER:  p = {{8{hc == '0}}, {8{vc == '0}},
                        {8{hc == CORDW'(H_ACTIVE - 1) || vc == CORDW'(V_ACTIVE - 1)}}};
      PAT_CHECKER: p = {24{xa[5] ^ vc[5]}};
      PAT_RAMP:    p = {3{xa}};
      default:     p = '1;
    endcase
  end
  function automatic logic [COLW-1:0] widen(input logic [7:0] c);
    return COLW'(c) << (COLW - 8);
  endfunction
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      de <= 1'b0;
      frame_start <= 1'b0;
      rgb <= '0;
      mode_q <= PAT_BLACK;
    end else begin
      sx <= hc;
      sy <= vc;
      hsync <= hs_act ? H_POL : ~H_POL;
      vsync <= vs_act ? V_POL : ~V_POL;
      de <= de_raw;
      frame_start <= hc == '0 && vc == '0;
      rgb <= de_raw ? {widen(p[23:16]), widen(p[15:8]), widen(p[7:0])} : '0;
      if (last_px) mode_q <= pattern_mode_e'(mode);
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: cycle-tagged scoreboard bench for video_pattern_gen on a reduced raster
module tb_video_pattern_gen;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 72, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef PATTERN_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif
  logic clk_pix = 1'b0;
  logic rst;
  logic [2:0] mode;
  logic [9:0] sx, sy;
  logic hsync, vsync, de, frame_start;
  logic [23:0] rgb;

  video_pattern_gen #(
    .CORDW(10), .COLW(8),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .clk_pix(clk_pix),
    .rst(rst),
    .mode(mode),
    .sx(sx),
    .sy(sy),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .frame_start(frame_start),
    .rgb(rgb)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [9:0]  sx, sy;
    logic        hs, vs, de, fs;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_fail = 0;
  int t0 = 0;

  task automatic expect_px(input string n, input int f, input int x, input int y, input logic [23:0] c);
    exp_t e;
    e.cyc = t0 + f * FT + y * HT + x;
    e.name = n;
    e.sx = 10'(x);
    e.sy = 10'(y);
    e.hs = !(x >= HA + HF && x < HA + HF + HS);
    e.vs = !(y >= VA + VF && y < VA + VF + VS);
    e.de = x < HA && y < VA;
    e.fs = x == 0 && y == 0;
    e.rgb = c;
    q.push_back(e);
  endtask

  task automatic expect_rst(input string n, input int c);
    exp_t e;
    e.cyc = c;
    e.name = n;
    e.sx = '0;
    e.sy = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.de = 1'b0;
    e.fs = 1'b0;
    e.rgb = '0;
    q.push_back(e);
  endtask

  task automatic check(input string n, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", n, got, want);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk_pix);
      #1;
    end
  endtask

  function automatic logic [23:0] grey(input int v);
    return {3{8'(v)}};
  endfunction

  bit have_fs = 1'b0;
  int last_fs = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  always @(negedge clk_pix) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_cmp++;
        if ({sx, sy, hsync, vsync, de, frame_start, rgb} !==
            {q[i].sx, q[i].sy, q[i].hs, q[i].vs, q[i].de, q[i].fs, q[i].rgb}) begin
          n_fail++;
          $display("FAIL %s @%0d: got sx=%0d sy=%0d hs=%b vs=%b de=%b fs=%b rgb=%h, want sx=%0d sy=%0d hs=%b vs=%b de=%b fs=%b rgb=%h",
                   q[i].name, cyc, sx, sy, hsync, vsync, de, frame_start, rgb,
                   q[i].sx, q[i].sy, q[i].hs, q[i].vs, q[i].de, q[i].fs, q[i].rgb);
        end
        q.delete(i);
      end
    end
    if (rst) have_fs = 1'b0;
    else begin
      if (frame_start === 1'b1) begin
        if (have_fs) begin
          check("fs_period", cyc - last_fs, FT);
          check("de_per_frame", de_cnt, HA * VA);
          check("hsync_low_per_frame", hs_cnt, VT * HS);
          check("vsync_low_per_frame", vs_cnt, VS * HT);
        end
        have_fs = 1'b1;
        last_fs = cyc;
        de_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
      end
      de_cnt += int'(de === 1'b1);
      hs_cnt += int'(hsync === 1'b0);
      vs_cnt += int'(vsync === 1'b0);
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    mode = 3'd0;
    expect_rst("reset_state", 2);
    repeat (3) @(posedge clk_pix);
    #1 rst = 1'b0;
    t0 = cyc + 1;
    expect_px("first_px", 0, 0, 0, 24'h0);
    expect_px("h_fp_start", 0, 64, 0, 24'h0);
    expect_px("hs_first", 0, 68, 0, 24'h0);
    expect_px("hs_last", 0, 75, 0, 24'h0);
    expect_px("hs_end", 0, 76, 0, 24'h0);
    expect_px("line_end", 0, 79, 0, 24'h0);
    expect_px("active_last", 0, 63, 71, 24'h0);
    expect_px("v_blank", 0, 0, 72, 24'h0);
    expect_px("vs_first", 0, 0, 74, 24'h0);
    expect_px("vs_end", 0, 0, 76, 24'h0);
    expect_px("frame_last", 0, 79, 78, 24'h0);
    expect_px("bar_white", 1, 0, 0, 24'hffffff);
    expect_px("bar_white_edge", 1, 7, 3, 24'hffffff);
    expect_px("bar_yellow", 1, 8, 0, 24'hffff00);
    expect_px("bar_cyan", 1, 16, 1, 24'h00ffff);
    expect_px("bar_red", 1, 40, 3, 24'hff0000);
    expect_px("bar_blue", 1, 48, 2, 24'h0000ff);
    expect_px("bar_black", 1, 63, 5, 24'h000000);
    expect_px("bar_blank", 1, 64, 1, 24'h000000);
    expect_px("bar_vblank", 1, 0, 72, 24'h000000);
    expect_px("xor_a", 2, 27, 66, ANIM ? 24'h741d42 : 24'h6c1b42);
    expect_px("xor_b", 2, 5, 70, ANIM ? 24'h000746 : 24'h000546);
    expect_px("black_hold_a", 3, 20, 10, 24'h0);
    expect_px("black_hold_b", 3, 0, 40, 24'h0);
    expect_px("border_corner", 4, 0, 0, 24'hffff00);
    expect_px("border_left", 4, 0, 5, 24'hff0000);
    expect_px("border_top", 4, 5, 0, 24'h00ff00);
    expect_px("border_right", 4, 63, 10, 24'h0000ff);
    expect_px("border_bottom", 4, 10, 71, 24'h0000ff);
    expect_px("border_bl", 4, 0, 71, 24'hff00ff);
    expect_px("border_inner", 4, 10, 10, 24'h0);
    expect_px("ramp_x0", 5, 0, 3, grey(ANIM ? 5 : 0));
    expect_px("ramp_x17", 5, 17, 3, grey(ANIM ? 22 : 17));
    expect_px("ramp_pre_rst", 5, 30, 20, grey(ANIM ? 35 : 30));
    wait_cyc(t0 + 10);
    mode = 3'd2;
    wait_cyc(t0 + FT + 10);
    mode = 3'd1;
    wait_cyc(t0 + 2 * FT + 10);
    mode = 3'd0;
    wait_cyc(t0 + 3 * FT + 30 * HT);
    mode = 3'd3;
    wait_cyc(t0 + 4 * FT + 10);
    mode = 3'd5;
    c = t0 + 5 * FT + 20 * HT + 30;
    wait_cyc(c);
    rst = 1'b1;
    expect_rst("mid_rst_state", c + 1);
    wait_cyc(c + 1);
    rst = 1'b0;
    t0 = c + 2;
    expect_px("restart_px", 0, 0, 0, 24'h0);
    expect_px("mode_q_cleared", 0, 9, 2, 24'h0);
    expect_px("anim_x0_f1", 1, 0, 1, grey(ANIM ? 1 : 0));
    expect_px("ramp_x9_f1", 1, 9, 2, grey(ANIM ? 10 : 9));
    expect_px("chk_white_a", 2, 32, 0, 24'hffffff);
    expect_px("chk_black_a", 2, 40, 40, 24'h0);
    expect_px("chk_white_b", 2, 0, 33, 24'hffffff);
    expect_px("chk_black_b", 2, 10, 10, 24'h0);
    wait_cyc(t0 + FT + 10);
    mode = 3'd4;
    wait_cyc(t0 + 3 * FT + 2);
    check("pending_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
